// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core datapath (priority) and a host port.
// A bounded wait forces a host slot by stalling the core; hold mode gives the host exclusive access.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_read,
  input  logic              core_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_hold,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | no host request pending against a busy core
  // WAIT  | host request pending, core kept ownership, counting
  // FORCE | one-cycle host slot, core stalled and re-executes next cycle
  // HOLD  | host-exclusive mode, core stalled every cycle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE, S_HOLD} state_t;

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  state_t            state_q;
  logic [3:0]        wait_cnt_q;
  logic [3:0]        wait_cnt_d;
  logic [DATA_W-1:0] host_rdata_q;
  logic              host_valid_q;
  logic              core_busy;

  assign core_busy  = core_read | core_write;
  assign wait_cnt_d = wait_cnt_q + 4'd1;
  assign core_rdata = mem_rdata;
  assign host_rdata = host_rdata_q;
  assign host_valid = host_valid_q;

  always_comb begin
    host_gnt   = 1'b0;
    core_stall = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE, S_WAIT: host_gnt = host_req & ~core_busy;
        S_FORCE, S_HOLD: begin
          core_stall = 1'b1;
          host_gnt   = host_req;
        end
        default: host_gnt = 1'b0;
      endcase
    end
  end

  // Address/data default to the core fields whenever the host is not the owner.
  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_read  = ~host_we;
      mem_write = host_we;
    end else if (!reset && !core_stall) begin
      mem_read  = core_read;
      mem_write = core_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 4'd0;
      host_rdata_q <= '0;
      host_valid_q <= 1'b0;
    end else begin
      host_valid_q <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_rdata_q <= mem_rdata;

      if (host_hold) begin
        state_q    <= S_HOLD;
        wait_cnt_q <= 4'd0;
      end else begin
        case (state_q)
          S_IDLE, S_WAIT: begin
            if (core_busy && host_req) begin
              wait_cnt_q <= wait_cnt_d;
              state_q    <= (wait_cnt_d == MaxWaitC) ? S_FORCE : S_WAIT;
            end else begin
              // granted, nothing pending, or request withdrawn before a grant
              wait_cnt_q <= 4'd0;
              state_q    <= S_IDLE;
            end
          end
          default: begin
            wait_cnt_q <= 4'd0;
            state_q    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a behavioural memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_read, core_write;
  logic [7:0]  core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        core_stall;
  logic        host_req, host_we, host_hold;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        host_valid;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_hold(host_hold), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_valid(host_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic rst, cr, cw; logic [7:0] caddr;
    logic hr, hwe; logic [7:0] haddr; logic [31:0] hwd; logic hh;
    logic gnt, stall, mr, mw; logic [7:0] maddr; logic valid; logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic cr, input logic cw, input int caddr,
                     input logic hr, input logic hwe, input int haddr, input logic [31:0] hwd,
                     input logic hh, input logic gnt, input logic stall, input logic mr,
                     input logic mw, input int maddr, input logic valid, input logic [31:0] rdata);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw; v.caddr = 8'(caddr);
    v.hr = hr; v.hwe = hwe; v.haddr = 8'(haddr); v.hwd = hwd; v.hh = hh;
    v.gnt = gnt; v.stall = stall; v.mr = mr; v.mw = mw; v.maddr = 8'(maddr);
    v.valid = valid; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;
  localparam logic [31:0] C11 = 32'hC0DE0011;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[8'h10] = DB;

    // rst cr cw caddr  hr hwe haddr hwd hh | gnt stall mr mw maddr valid rdata
    add(1,0,1,8'h05, 1,0,8'h0A,0,0,  0,0,0,0,8'h05, 0,0);        // outputs forced in reset
    add(0,0,0,0,     1,0,8'h10,0,0,  1,0,1,0,8'h10, 0,0);        // idle core: immediate grant
    add(0,0,0,0,     0,0,0,0,0,      0,0,0,0,0,     1,DB);
    add(0,0,0,0,     0,0,0,0,0,      0,0,0,0,0,     0,DB);
    add(0,1,0,8'h33, 1,0,8'h40,0,0,  0,0,1,0,8'h33, 0,DB);       // core load wins, go WAIT
    add(0,1,0,8'h34, 0,0,8'h40,0,0,  0,0,1,0,8'h34, 0,DB);       // request withdrawn
    for (int i = 0; i < 4; i++)
      add(0,0,1,8'h50+i, 1,1,8'h20,A5,0, 0,0,0,1,8'h50+i, 0,DB); // 4 ungranted cycles
    add(0,0,1,8'h54, 1,1,8'h20,A5,0, 1,1,0,1,8'h20, 0,DB);       // FORCE slot
    add(0,0,1,8'h54, 0,0,0,0,0,      0,0,0,1,8'h54, 0,DB);       // core store re-executes
    add(0,0,0,0,     0,0,0,0,0,      0,0,0,0,0,     0,DB);
    for (int i = 0; i < 3; i++)
      add(0,1,0,8'h60+i, 1,0,8'h11,0,0, 0,0,1,0,8'h60+i, 0,DB);  // wait_cnt reaches 3
    add(1,1,0,8'h63, 1,0,8'h11,0,0,  0,0,0,0,8'h63, 0,DB);       // reset in WAIT
    for (int i = 0; i < 4; i++)
      add(0,1,0,8'h64+i, 1,0,8'h11,0,0, 0,0,1,0,8'h64+i, 0,0);   // full wait restarts from 0
    add(0,1,0,8'h68, 1,0,8'h11,0,0,  1,1,1,0,8'h11, 0,0);        // FORCE host read
    add(0,0,0,0,     0,0,0,0,0,      0,0,0,0,0,     1,C11);
    add(0,0,1,8'h70, 0,0,0,0,1,      0,0,0,1,8'h70, 0,C11);      // hold sampled, not yet stalled
    for (int i = 0; i < 8; i++)
      add(0,0,1,8'h71, 1,1,i,32'hB0+i,1, 1,1,0,1,i, 0,C11);      // bulk load in HOLD
    add(0,0,1,8'h71, 0,0,0,0,1,      0,1,0,0,8'h71, 0,C11);
    add(0,0,1,8'h71, 0,0,0,0,0,      0,1,0,0,8'h71, 0,C11);      // hold dropped, still HOLD
    add(0,0,1,8'h71, 0,0,0,0,0,      0,0,0,1,8'h71, 0,C11);      // core store resumes
    add(0,0,0,0,     0,0,0,0,0,      0,0,0,0,0,     0,C11);

    reset = 1'b1; core_read = 0; core_write = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_hold = 0;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      #1;
      reset = vecs[k].rst; core_read = vecs[k].cr; core_write = vecs[k].cw;
      core_addr = vecs[k].caddr; core_wdata = 32'h100 + 32'(vecs[k].caddr);
      host_req = vecs[k].hr; host_we = vecs[k].hwe; host_addr = vecs[k].haddr;
      host_wdata = vecs[k].hwd; host_hold = vecs[k].hh;
      @(negedge clk);
      chk($sformatf("v%0d host_gnt", k),   32'(host_gnt),   32'(vecs[k].gnt));
      chk($sformatf("v%0d core_stall", k), 32'(core_stall), 32'(vecs[k].stall));
      chk($sformatf("v%0d mem_read", k),   32'(mem_read),   32'(vecs[k].mr));
      chk($sformatf("v%0d mem_write", k),  32'(mem_write),  32'(vecs[k].mw));
      chk($sformatf("v%0d mem_addr", k),   32'(mem_addr),   32'(vecs[k].maddr));
      chk($sformatf("v%0d host_valid", k), 32'(host_valid), 32'(vecs[k].valid));
      chk($sformatf("v%0d host_rdata", k), host_rdata,      vecs[k].rdata);
      chk($sformatf("v%0d core_rdata", k), core_rdata,      mem[vecs[k].maddr]);
      @(posedge clk);
    end

    #1;
    chk("mem20 host write", mem[8'h20], A5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("mem%0h core store", 8'h50 + i), mem[8'h50 + i], 32'h150 + 32'(i));
    for (int i = 0; i < 8; i++)
      chk($sformatf("mem%0h hold write", i), mem[i], 32'hB0 + 32'(i));
    chk("mem70 core store", mem[8'h70], 32'h170);
    chk("mem71 core store", mem[8'h71], 32'h171);
    chk("mem0a untouched", mem[8'h0A], 32'hC0DE000A);
    chk("mem10 untouched", mem[8'h10], DB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Cycle-level arbiter that shares the single-port synchronous data memory between the single-cycle core datapath and an external host port (program loader / debug). The core has priority, and the host is served in idle memory cycles. A bounded-wait counter forces a host slot by stalling the core. A hold mode gives the host exclusive access for bulk loads. It sits between the datapath's load/store signals and the data memory instance.

## Interface
- ADDR_W, 8, memory word address width
- DATA_W, 32, data width
- MAX_WAIT, 4, host wait cycles tolerated before a forced slot (1..15)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- core_read  in  1  core load this cycle (datapath MemRead)
- core_write  in  1  core store this cycle (datapath MemWrite)
- core_addr  in  ADDR_W  core address (ALU result low bits)
- core_wdata  in  DATA_W  core store data
- core_rdata  out  DATA_W  load data to core (mem_rdata pass-through)
- core_stall  out  1  freeze PC and suppress RegWrite this cycle
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_hold  in  1  exclusive host mode request
- host_gnt  out  1  host access performed this cycle
- host_rdata  out  DATA_W  registered host read data
- host_valid  out  1  host_rdata valid (1-cycle pulse)
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_rdata  in  DATA_W  from memory; combinational read within the cycle

## Operation
- Memory contract: a write commits at the rising edge when mem_write=1. mem_rdata is valid in the same cycle as mem_read.
- States: IDLE, WAIT, FORCE, HOLD. wait_cnt is 4 bits.
- Owner per cycle:
  - Core owns when core_stall=0.
  - Host owns when host_gnt=1.
  - host_gnt and a core memory access never occur in the same cycle.
- IDLE/WAIT:
  - If core_read|core_write, the core owns. A pending host_req is not granted, wait_cnt increments, and the next state is WAIT.
  - Else if host_req, the host owns: host_gnt=1, wait_cnt clears, next state IDLE.
- WAIT → FORCE when a non-granted cycle brings wait_cnt to MAX_WAIT.
- FORCE (single cycle):
  - core_stall=1, the core's mem_read/mem_write are masked, and the host owns with host_gnt=1.
  - Next state IDLE, wait_cnt cleared.
  - The stalled core instruction re-executes the following cycle (PC held).
- HOLD:
  - Entered from any state on the edge where host_hold=1.
  - core_stall=1 every cycle. host_gnt=host_req.
  - Exits to IDLE on the edge where host_hold=0. wait_cnt cleared.
- host_req falling in WAIT without a grant returns to IDLE with wait_cnt cleared; no grant occurs.
- Host handshake:
  - Command fields are held stable while host_req=1 until host_gnt.
  - host_req still high after a grant is a new request.
- Host read: host_rdata<=mem_rdata on the granting edge; host_valid=1 the next cycle only.
- Host write: committed on the granting edge; no host_valid.
- Mux: mem_* are driven from the owner's fields. With no owner, mem_read=mem_write=0 and mem_addr/mem_wdata are don't-care (drive core fields).
- core_rdata=mem_rdata always; the core must ignore it while stalled.

## Timing
- Reset (synchronous) sets state=IDLE, wait_cnt=0, host_rdata=0, host_valid=0.
- While reset=1, these outputs are forced combinationally: host_gnt=0, core_stall=0, mem_read=0, mem_write=0.
- host_gnt, core_stall and the mem_* signals are combinational from state and inputs. All state updates occur on rising edges.
- Host latency: a grant in the request cycle if the core is idle. The worst case with the core busy every cycle is MAX_WAIT+1 cycles from request to grant.
- The core loses at most 1 cycle per MAX_WAIT+1 cycles outside HOLD.
- host_hold taking effect: the first stalled cycle is the cycle after host_hold is sampled high.
- Reset mid-FORCE or mid-HOLD: the next cycle is IDLE. Any host access not yet granted is dropped, and the host must re-request.

## Test plan
- Core idle, host read addr 0x10 (memory holds 0xDEADBEEF) → host_gnt in the request cycle; host_valid=1 with host_rdata=0xDEADBEEF the next cycle; core_stall stays 0.
- Core storing every cycle, host write 0xA5A5A5A5 to 0x20, MAX_WAIT=4 → 4 cycles ungranted, then a FORCE cycle with core_stall=1, mem_write from the host, and mem[0x20]=0xA5A5A5A5; core stores resume the next cycle with no lost store.
- Core load and host request in the same cycle with wait_cnt=0 → the core owns (mem_addr=core_addr), host_gnt=0, state WAIT.
- host_hold=1 for 10 cycles with host writes to 0x00..0x07 → core_stall high from the cycle after assertion until host_hold drops; all 8 words written; no core memory access.
- reset asserted during WAIT (wait_cnt=3) → next cycle IDLE, wait_cnt=0, host_valid=0, no grant until host_req is re-presented.
- Host requests a read then deasserts host_req in WAIT before a grant → no grant, no host_valid, wait_cnt=0.
